// File: rtl/instr_encoder_if.sv
// Request/response bundle between a program source and the instruction encoder.
// The master drives instruction fields; the slave returns handshake and imem-side results.
interface instr_encoder_if #(
    parameter int ADDR_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        op_sel;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [20:0]       imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;

    modport master (
        output in_valid, op_sel, rd, rs1, rs2, funct3, funct7, imm,
        input  in_ready, imem_we, imem_addr, imem_wdata, count, full, err
    );

    modport slave (
        input  in_valid, op_sel, rd, rs1, rs2, funct3, funct7, imm,
        output in_ready, imem_we, imem_addr, imem_wdata, count, full, err
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs RV32I instruction fields into machine words and streams them into
// consecutive imem addresses; one word per two cycles, stops when imem is full.
module instr_encoder #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    instr_encoder_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, WRITE, FULL} state_t;

    localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic [ADDR_W:0]   count_reg, count_next;
    logic              err_reg, err_next;

    logic [31:0]       enc_word;
    logic              enc_legal;
    logic [20:11]      sign_match;
    logic              fits12, fits13;
    logic [ADDR_W:0]   count_inc;

    // Immediate fits N signed bits when every bit above N-1 copies the sign bit.
    assign sign_match[20] = 1'b1;
    generate
        for (genvar gi = 11; gi < 20; gi++) begin : g_sign
            assign sign_match[gi] = (bus.imm[gi] == bus.imm[20]);
        end
    endgenerate
    assign fits12 = &sign_match[20:11];
    assign fits13 = &sign_match[20:12];

    always_comb begin
        enc_word  = 32'd0;
        enc_legal = 1'b0;
        case (bus.op_sel)
            3'd0: begin
                enc_word  = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, 7'b0110011};
                enc_legal = 1'b1;
            end
            3'd1: begin
                enc_word  = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], 7'b0100011};
                enc_legal = fits12;
            end
            3'd2: begin
                enc_word  = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, 7'b0010011};
                enc_legal = fits12;
            end
            3'd3: begin
                enc_word  = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, 7'b0000011};
                enc_legal = fits12;
            end
            3'd4: begin
                enc_word  = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                             bus.imm[4:1], bus.imm[11], 7'b1100011};
                enc_legal = fits13 && !bus.imm[0];
            end
            3'd5: begin
                enc_word  = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                             bus.rd, 7'b1101111};
                enc_legal = !bus.imm[0];
            end
            3'd6: begin
                enc_word  = {bus.imm[11:0], bus.rs1, 3'b000, bus.rd, 7'b1100111};
                enc_legal = fits12;
            end
            default: begin
                enc_word  = 32'd0;
                enc_legal = 1'b0;
            end
        endcase
    end

    assign count_inc = count_reg + ONE_C;

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        count_next = count_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    if (enc_legal) begin
                        wdata_next = enc_word;
                        addr_next  = count_reg[ADDR_W-1:0];
                        state_next = WRITE;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            WRITE: begin
                count_next = count_inc;
                state_next = (count_inc == DEPTH_C) ? FULL : IDLE;
            end
            FULL:    state_next = FULL;
            default: state_next = IDLE;
        endcase
        // Restart wins over everything, including a write already in flight.
        if (clear) begin
            state_next = IDLE;
            addr_next  = '0;
            wdata_next = 32'd0;
            count_next = '0;
            err_next   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            wdata_reg <= 32'd0;
            count_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            count_reg <= count_next;
            err_reg   <= err_next;
        end
    end

    assign bus.in_ready   = (state_reg == IDLE);
    assign bus.imem_we    = (state_reg == WRITE) && !clear;
    assign bus.imem_addr  = addr_reg;
    assign bus.imem_wdata = wdata_reg;
    assign bus.count      = count_reg;
    assign bus.full       = (state_reg == FULL);
    assign bus.err        = err_reg;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: table of encodings/rejections plus
// hand-written sequences for back-to-back, full, clear-in-write and reset.
module tb_instr_encoder;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [20:0] imm;
        logic        legal;
        logic [31:0] word;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_count = 0;
    logic exp_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.op_sel = v.op;
        bus.rd     = v.rd;
        bus.rs1    = v.rs1;
        bus.rs2    = v.rs2;
        bus.funct3 = v.f3;
        bus.funct7 = v.f7;
        bus.imm    = v.imm;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_we"},    32'(bus.imem_we), 32'd0);
        chk({tag, "_addr"},  32'(bus.imem_addr), 32'd0);
        chk({tag, "_wdata"}, bus.imem_wdata, 32'd0);
        chk({tag, "_count"}, 32'(bus.count), 32'd0);
        chk({tag, "_full"},  32'(bus.full), 32'd0);
        chk({tag, "_err"},   32'(bus.err), 32'd0);
    endtask

    // Called at posedge+1; returns at posedge+1 after the transaction settles.
    task automatic apply(input vec_t v);
        int guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("ready_wait", 32'(bus.in_ready), 32'd1);
        drive(v);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        if (v.legal) begin
            chk("strobe", 32'(bus.imem_we), 32'd1);
            chk("addr",   32'(bus.imem_addr), 32'(exp_count));
            chk("wdata",  bus.imem_wdata, v.word);
            chk("busy",   32'(bus.in_ready), 32'd0);
            @(posedge clk); #1;
            exp_count++;
            chk("strobe_end", 32'(bus.imem_we), 32'd0);
            chk("wdata_hold", bus.imem_wdata, v.word);
            if (exp_count < DEPTH) begin
                chk("ready_back", 32'(bus.in_ready), 32'd1);
            end else begin
                chk("full_set",   32'(bus.full), 32'd1);
                chk("ready_full", 32'(bus.in_ready), 32'd0);
            end
        end else begin
            exp_err = 1'b1;
            chk("reject_we",    32'(bus.imem_we), 32'd0);
            chk("reject_ready", 32'(bus.in_ready), 32'd1);
        end
        chk("count", 32'(bus.count), 32'(exp_count));
        chk("err",   32'(bus.err), 32'(exp_err));
        $display("txn op=%0d imm=0x%06h legal=%0b word=0x%08h count=%0d err=%0b",
                 v.op, v.imm, v.legal, bus.imem_wdata, bus.count, bus.err);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        exp_count = 0;
        exp_err   = 1'b0;
    endtask

    vec_t vecs[17];
    vec_t r_add, s_sw, v;

    initial begin
        // op, rd, rs1, rs2, f3, f7, imm, legal, word
        vecs[0]  = '{3'd2, 5'd1,  5'd0, 5'd7, 3'd0, 7'd0, 21'd5,       1'b1, 32'h00500093};
        vecs[1]  = '{3'd0, 5'd3,  5'd1, 5'd2, 3'd0, 7'd0, 21'd0,       1'b1, 32'h002081B3};
        vecs[2]  = '{3'd1, 5'd31, 5'd1, 5'd2, 3'd2, 7'd0, 21'd8,       1'b1, 32'h0020A423};
        vecs[3]  = '{3'd4, 5'd0,  5'd1, 5'd2, 3'd0, 7'd0, 21'h1FFFFC,  1'b1, 32'hFE208EE3};
        vecs[4]  = '{3'd5, 5'd1,  5'd0, 5'd0, 3'd0, 7'd0, 21'd8,       1'b1, 32'h008000EF};
        vecs[5]  = '{3'd6, 5'd1,  5'd5, 5'd0, 3'd7, 7'd0, 21'd0,       1'b1, 32'h000280E7};
        vecs[6]  = '{3'd3, 5'd5,  5'd2, 5'd0, 3'd2, 7'd0, 21'h1FFFFF,  1'b1, 32'hFFF12283};
        vecs[7]  = '{3'd7, 5'd1,  5'd1, 5'd1, 3'd0, 7'd0, 21'd0,       1'b0, 32'h0};
        vecs[8]  = '{3'd2, 5'd1,  5'd0, 5'd0, 3'd0, 7'd0, 21'd2048,    1'b0, 32'h0};
        vecs[9]  = '{3'd4, 5'd0,  5'd1, 5'd2, 3'd0, 7'd0, 21'd3,       1'b0, 32'h0};
        vecs[10] = '{3'd2, 5'd2,  5'd3, 5'd0, 3'd0, 7'd0, 21'h1FF800,  1'b1, 32'h80018113};
        vecs[11] = '{3'd2, 5'd1,  5'd1, 5'd0, 3'd0, 7'd0, 21'd2047,    1'b1, 32'h7FF08093};
        vecs[12] = '{3'd4, 5'd0,  5'd1, 5'd2, 3'd0, 7'd0, 21'd4096,    1'b0, 32'h0};
        vecs[13] = '{3'd5, 5'd1,  5'd0, 5'd0, 3'd0, 7'd0, 21'd1,       1'b0, 32'h0};
        vecs[14] = '{3'd1, 5'd0,  5'd1, 5'd2, 3'd2, 7'd0, 21'h1FF7FF,  1'b0, 32'h0};
        vecs[15] = '{3'd4, 5'd0,  5'd0, 5'd0, 3'd1, 7'd0, 21'h1FF000,  1'b1, 32'h80001063};
        vecs[16] = '{3'd5, 5'd0,  5'd0, 5'd0, 3'd0, 7'd0, 21'h1FFFFE,  1'b1, 32'hFFFFF06F};
        r_add = vecs[1];
        s_sw  = vecs[2];

        bus.in_valid = 1'b0;
        drive(vecs[0]);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_reset_vals("reset");

        for (int i = 0; i < 17; i++) apply(vecs[i]);

        // Back-to-back with in_valid held high.
        pulse_clear();
        drive(r_add);
        bus.in_valid = 1'b1;
        chk("b2b_ready0", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        chk("b2b_ready1", 32'(bus.in_ready), 32'd0);
        chk("b2b_we1",    32'(bus.imem_we), 32'd1);
        chk("b2b_addr1",  32'(bus.imem_addr), 32'd0);
        chk("b2b_data1",  bus.imem_wdata, 32'h002081B3);
        drive(s_sw);
        @(posedge clk); #1;
        chk("b2b_ready2", 32'(bus.in_ready), 32'd1);
        chk("b2b_we2",    32'(bus.imem_we), 32'd0);
        chk("b2b_count2", 32'(bus.count), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("b2b_ready3", 32'(bus.in_ready), 32'd0);
        chk("b2b_we3",    32'(bus.imem_we), 32'd1);
        chk("b2b_addr3",  32'(bus.imem_addr), 32'd1);
        chk("b2b_data3",  bus.imem_wdata, 32'h0020A423);
        @(posedge clk); #1;
        chk("b2b_count4", 32'(bus.count), 32'd2);
        $display("txn back-to-back R,S count=%0d", bus.count);

        // Fill imem, then a 17th request must be ignored.
        pulse_clear();
        for (int i = 0; i < DEPTH; i++) begin
            v = '{3'd2, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 21'(i), 1'b1,
                  {12'(i), 20'h00093}};
            apply(v);
        end
        drive(vecs[0]);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("full_no_we", 32'(bus.imem_we), 32'd0);
        end
        bus.in_valid = 1'b0;
        chk("full_count", 32'(bus.count), 32'd16);
        chk("full_flag",  32'(bus.full), 32'd1);
        $display("txn request while full count=%0d full=%0b", bus.count, bus.full);
        pulse_clear();
        check_reset_vals("clear");
        v = '{3'd2, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 21'd42, 1'b1, 32'h02A00093};
        apply(v);

        // Clear during the WRITE cycle aborts the strobe.
        drive(vecs[0]);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("cw_we_before", 32'(bus.imem_we), 32'd1);
        clear = 1'b1;
        #1;
        chk("cw_we_abort", 32'(bus.imem_we), 32'd0);
        @(posedge clk); #1;
        clear = 1'b0;
        exp_count = 0;
        exp_err   = 1'b0;
        chk("cw_count", 32'(bus.count), 32'd0);
        chk("cw_we",    32'(bus.imem_we), 32'd0);
        chk("cw_ready", 32'(bus.in_ready), 32'd1);
        $display("txn clear in WRITE count=%0d", bus.count);

        // Reset with a request pending.
        apply(vecs[7]);
        apply(vecs[0]);
        drive(vecs[1]);
        bus.in_valid = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.in_valid = 1'b0;
        check_reset_vals("rst_valid");
        @(posedge clk); #1;
        chk("rst_no_we",    32'(bus.imem_we), 32'd0);
        chk("rst_no_count", 32'(bus.count), 32'd0);
        $display("txn reset with in_valid count=%0d err=%0b", bus.count, bus.err);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
